// File: rtl/iorq_port_fsm_if.sv
// CPU IO-bus side of the port decoder: positive-logic strobes in, per-port
// ticks, read-enables, captured write data and wait request out.
interface iorq_port_fsm_if #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned NUM_PORTS = 4
);
   logic                 iorq;
   logic                 rd;
   logic                 wr;
   logic [ADDR_W-1:0]    addr;
   logic [7:0]           data_in;
   logic [NUM_PORTS-1:0] wr_tick;
   logic [NUM_PORTS-1:0] rd_tick;
   logic [NUM_PORTS-1:0] rd_en;
   logic [7:0]           wr_data;
   logic                 wait_req;

   modport master (
      output iorq, rd, wr, addr, data_in,
      input  wr_tick, rd_tick, rd_en, wr_data, wait_req
   );

   modport slave (
      input  iorq, rd, wr, addr, data_in,
      output wr_tick, rd_tick, rd_en, wr_data, wait_req
   );
endinterface

// File: rtl/iorq_port_fsm.sv
// Decodes NUM_PORTS consecutive Z8S180 IO addresses; per matched bus cycle it
// inserts WAIT_CYCLES wait states and emits one rd/wr tick for the addressed port.
module iorq_port_fsm #(
   parameter int unsigned        ADDR_W      = 8,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = ADDR_W'(8'h40),
   parameter int unsigned        NUM_PORTS   = 4,
   parameter int unsigned        WAIT_CYCLES = 0
) (
   input  logic            phi,
   input  logic            reset_n,
   iorq_port_fsm_if.slave  bus
);

   localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned CMP_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT,
      S_TICK,
      S_HOLD,
      S_IGNORE
   } state_e;

   state_e               state_q,    state_d;
   logic [CNT_W-1:0]     cnt_q,      cnt_d;
   logic [IDX_W-1:0]     idx_q,      idx_d;
   logic                 is_wr_q,    is_wr_d;
   logic                 seen_low_q, seen_low_d;
   logic [NUM_PORTS-1:0] wr_tick_q,  wr_tick_d;
   logic [NUM_PORTS-1:0] rd_tick_q,  rd_tick_d;
   logic [NUM_PORTS-1:0] rd_en_q,    rd_en_d;
   logic [7:0]           wr_data_q,  wr_data_d;
   logic                 wait_req_q, wait_req_d;

   logic [ADDR_W-1:0]    offset;
   logic                 addr_hit;
   logic [IDX_W-1:0]     port_idx;
   logic                 cap_go;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
      port_onehot = NUM_PORTS'(1) << idx;
   endfunction

   // Port window decode; offset wraps so addresses below BASE_ADDR miss.
   assign offset   = bus.addr - BASE_ADDR;
   assign addr_hit = {1'b0, offset} < CMP_W'(NUM_PORTS);
   assign port_idx = IDX_W'(offset);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      is_wr_d    = is_wr_q;
      seen_low_d = seen_low_q | ~bus.iorq;
      wr_tick_d  = '0;
      rd_tick_d  = '0;
      rd_en_d    = rd_en_q;
      wr_data_d  = wr_data_q;
      wait_req_d = 1'b0;
      cap_go     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // After reset a cycle already in flight is skipped until iorq drops.
            if (bus.iorq) begin
               if (!seen_low_q)            state_d = S_IGNORE;
               else if (bus.rd || bus.wr)  cap_go  = 1'b1;
               else                        state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (!bus.iorq)                 state_d = S_IDLE;
            else if (bus.rd || bus.wr)     cap_go  = 1'b1;
         end
         S_WAIT: begin
            if (!bus.iorq) begin
               state_d = S_IDLE;
               rd_en_d = '0;
            end else if (cnt_q == '0) begin
               state_d = S_TICK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_TICK:   state_d = S_HOLD;
         S_HOLD:   if (!bus.iorq) state_d = S_IDLE;
         S_IGNORE: if (!bus.iorq) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (cap_go) begin
         if ((bus.rd && bus.wr) || !addr_hit) begin
            state_d = S_IGNORE;
         end else begin
            idx_d   = port_idx;
            is_wr_d = bus.wr;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = (WAIT_CYCLES == 0) ? S_TICK : S_WAIT;
            rd_en_d = bus.wr ? '0 : port_onehot(port_idx);
         end
      end

      if (!bus.iorq) rd_en_d = '0;

      wait_req_d = (state_d == S_WAIT);
      if (state_d == S_TICK) begin
         if (is_wr_d) begin
            wr_tick_d = port_onehot(idx_d);
            wr_data_d = bus.data_in;
         end else begin
            rd_tick_d = port_onehot(idx_d);
         end
      end
   end

   always_ff @(posedge phi or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         is_wr_q    <= 1'b0;
         seen_low_q <= 1'b0;
         wr_tick_q  <= '0;
         rd_tick_q  <= '0;
         rd_en_q    <= '0;
         wr_data_q  <= 8'h00;
         wait_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         is_wr_q    <= is_wr_d;
         seen_low_q <= seen_low_d;
         wr_tick_q  <= wr_tick_d;
         rd_tick_q  <= rd_tick_d;
         rd_en_q    <= rd_en_d;
         wr_data_q  <= wr_data_d;
         wait_req_q <= wait_req_d;
      end
   end

   assign bus.wr_tick  = wr_tick_q;
   assign bus.rd_tick  = rd_tick_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.wait_req = wait_req_q;

endmodule

// File: tb/tb_iorq_port_fsm.sv
// Bench for iorq_port_fsm: three instances (WAIT_CYCLES 0, 2, 3) share one
// stimulus stream and are checked against a timestamp-based cycle model.
module tb_iorq_port_fsm;

   localparam int unsigned ND   = 3;
   localparam int unsigned NP   = 4;
   localparam logic [7:0]  BASE = 8'h40;
   localparam int          W_OF [ND] = '{0, 2, 3};

   typedef struct packed {
      logic       iorq;
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] din;
   } stim_t;

   logic       phi = 1'b0;
   logic       reset_n = 1'b0;
   logic       iorq, rd, wr;
   logic [7:0] addr, din;

   always #5 phi = ~phi;

   iorq_port_fsm_if #(.ADDR_W(8), .NUM_PORTS(NP)) bus0 (), bus1 (), bus2 ();

   assign bus0.iorq = iorq; assign bus0.rd = rd; assign bus0.wr = wr;
   assign bus0.addr = addr; assign bus0.data_in = din;
   assign bus1.iorq = iorq; assign bus1.rd = rd; assign bus1.wr = wr;
   assign bus1.addr = addr; assign bus1.data_in = din;
   assign bus2.iorq = iorq; assign bus2.rd = rd; assign bus2.wr = wr;
   assign bus2.addr = addr; assign bus2.data_in = din;

   iorq_port_fsm #(.ADDR_W(8), .BASE_ADDR(BASE), .NUM_PORTS(NP), .WAIT_CYCLES(0))
      dut0 (.phi(phi), .reset_n(reset_n), .bus(bus0));
   iorq_port_fsm #(.ADDR_W(8), .BASE_ADDR(BASE), .NUM_PORTS(NP), .WAIT_CYCLES(2))
      dut1 (.phi(phi), .reset_n(reset_n), .bus(bus1));
   iorq_port_fsm #(.ADDR_W(8), .BASE_ADDR(BASE), .NUM_PORTS(NP), .WAIT_CYCLES(3))
      dut2 (.phi(phi), .reset_n(reset_n), .bus(bus2));

   // {wait_req, rd_en, rd_tick, wr_tick, wr_data}
   logic [20:0] act [ND];
   assign act[0] = {bus0.wait_req, bus0.rd_en, bus0.rd_tick, bus0.wr_tick, bus0.wr_data};
   assign act[1] = {bus1.wait_req, bus1.rd_en, bus1.rd_tick, bus1.wr_tick, bus1.wr_data};
   assign act[2] = {bus2.wait_req, bus2.rd_en, bus2.rd_tick, bus2.wr_tick, bus2.wr_data};

   bit          m_busy  [ND];
   bit          m_blk   [ND];
   bit          m_iswr  [ND];
   bit          m_rden  [ND];
   int          m_cap   [ND];
   int          m_port  [ND];
   logic [7:0]  m_wdata [ND];
   logic [20:0] m_exp   [ND];

   int cyc;
   int n_chk;
   int n_pass;

   function automatic logic [3:0] oh(input int p);
      logic [3:0] r;
      r    = '0;
      r[p] = 1'b1;
      return r;
   endfunction

   function automatic stim_t mk(input logic i, input logic r, input logic w,
                                input logic [7:0] a, input logic [7:0] d);
      stim_t s;
      s.iorq = i; s.rd = r; s.wr = w; s.addr = a; s.din = d;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      iorq = s.iorq; rd = s.rd; wr = s.wr; addr = s.addr; din = s.din;
   endtask

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_busy[d]  = 1'b0;
         m_blk[d]   = 1'b1;
         m_rden[d]  = 1'b0;
         m_wdata[d] = 8'h00;
         m_exp[d]   = '0;
      end
   endtask

   // A captured cycle is tracked by its capture edge; outputs follow from its age.
   task automatic model_edge();
      for (int d = 0; d < ND; d++) begin
         int         age;
         logic [7:0] off;
         bit         tick;
         if (m_busy[d]) begin
            age = cyc - m_cap[d];
            if (!iorq) begin
               m_rden[d] = 1'b0;
               if (age <= W_OF[d] || age >= W_OF[d] + 2) m_busy[d] = 1'b0;
            end
         end else if (m_blk[d]) begin
            if (!iorq) m_blk[d] = 1'b0;
         end else if (iorq && (rd || wr)) begin
            off = addr - BASE;
            if ((rd && wr) || off >= 8'(NP)) begin
               m_blk[d] = 1'b1;
            end else begin
               m_busy[d] = 1'b1;
               m_cap[d]  = cyc;
               m_port[d] = int'(off);
               m_iswr[d] = wr;
               m_rden[d] = rd;
            end
         end
         age  = cyc - m_cap[d];
         tick = m_busy[d] && (age == W_OF[d]);
         if (tick && m_iswr[d]) m_wdata[d] = din;
         m_exp[d] = {m_busy[d] && (age < W_OF[d]),
                     m_rden[d] ? oh(m_port[d]) : 4'h0,
                     (tick && !m_iswr[d]) ? oh(m_port[d]) : 4'h0,
                     (tick && m_iswr[d])  ? oh(m_port[d]) : 4'h0,
                     m_wdata[d]};
      end
   endtask

   task automatic step();
      @(posedge phi);
      cyc++;
      if (reset_n) model_edge();
      else         model_reset();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      drive(mk(1'b1, 1'b0, 1'b1, 8'h40, 8'hFF));
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== 21'h0) $display("FAIL reset_hold W=%0d got=%h exp=%h", W_OF[d], act[d], 21'h0);
            else n_pass++;
         end
      end
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) drive(mk(1'b0, 1'b0, 1'b0, 8'h40, 8'hFF));
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL reset_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
            if (i < 2) begin
               n_chk++;
               if (act[d] !== 21'h0) $display("FAIL reset_wait_drop W=%0d got=%h exp=%h", W_OF[d], act[d], 21'h0);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_write_wait();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h42, 8'hA5));
      repeat (6) q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h42, 8'hA5));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h42, 8'hA5));
      foreach (q[i]) begin
         drive(q[i]);
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL write_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
         end
         if (i == 1 || i == 2) begin
            n_chk++;
            if (act[1][20] !== 1'b1) $display("FAIL write_wait_req step=%0d got=%b exp=1", i, act[1][20]);
            else n_pass++;
         end
         if (i == 1) begin
            n_chk++;
            if (act[0][11:0] !== 12'h4A5) $display("FAIL write_w0_tick got=%h exp=%h", act[0][11:0], 12'h4A5);
            else n_pass++;
         end
         if (i == 3) begin
            n_chk++;
            if (act[1] !== {1'b0, 12'h004, 8'hA5}) $display("FAIL write_w2_tick got=%h exp=%h", act[1], {1'b0, 12'h004, 8'hA5});
            else n_pass++;
         end
         if (i >= 4 && i <= 6) begin
            n_chk++;
            if (act[1][11:8] !== 4'h0) $display("FAIL write_no_retick step=%0d got=%h exp=0", i, act[1][11:8]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_read();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h40, 8'h00));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h40, 8'h00));
      q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h40, 8'h00));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h40, 8'h00));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h40, 8'h00));
      foreach (q[i]) begin
         drive(q[i]);
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL read_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
         end
         if (i == 0) begin
            n_chk++;
            if (act[0][20:12] !== 9'h011) $display("FAIL read_capture got=%h exp=%h", act[0][20:12], 9'h011);
            else n_pass++;
         end
         if (i == 1 || i == 2) begin
            n_chk++;
            if (act[0][20:12] !== 9'h010) $display("FAIL read_rden_hold step=%0d got=%h exp=%h", i, act[0][20:12], 9'h010);
            else n_pass++;
         end
         if (i == 3) begin
            n_chk++;
            if (act[0][19:16] !== 4'h0) $display("FAIL read_rden_clear got=%h exp=0", act[0][19:16]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_unmatched();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h44, 8'h5A));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h44, 8'h5A));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h44, 8'h5A));
      q.push_back(mk(1'b1, 1'b1, 1'b1, 8'h41, 8'h5A));
      q.push_back(mk(1'b1, 1'b1, 1'b1, 8'h41, 8'h5A));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h41, 8'h5A));
      repeat (5) q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h43, 8'hC3));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h43, 8'hC3));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h43, 8'hC3));
      foreach (q[i]) begin
         drive(q[i]);
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL unmatched_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
            if (i == 0 || i == 1 || i == 3 || i == 4) begin
               n_chk++;
               if (act[d][20:8] !== 13'h0) $display("FAIL unmatched_quiet W=%0d step=%0d got=%h exp=0", W_OF[d], i, act[d][20:8]);
               else n_pass++;
            end
         end
         if (i == 6) begin
            n_chk++;
            if (act[0][11:0] !== 12'h8C3) $display("FAIL unmatched_follow_tick got=%h exp=%h", act[0][11:0], 12'h8C3);
            else n_pass++;
         end
      end
   endtask

   task automatic test_abort();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h41, 8'h77));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h41, 8'h77));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h41, 8'h77));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h41, 8'h77));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h42, 8'h3C));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h42, 8'h3C));
      foreach (q[i]) begin
         drive(q[i]);
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL abort_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
         end
         if (i == 0 || i == 1 || i == 5) begin
            n_chk++;
            if (act[2][20] !== 1'b1) $display("FAIL abort_wait_req step=%0d got=%b exp=1", i, act[2][20]);
            else n_pass++;
         end
         if (i == 2 || i == 3) begin
            n_chk++;
            if (act[2][20:8] !== 13'h0) $display("FAIL abort_no_tick step=%0d got=%h exp=0", i, act[2][20:8]);
            else n_pass++;
         end
      end
      // Asynchronous reset while dut2 is still counting wait states.
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (act[d] !== 21'h0) $display("FAIL abort_async_reset W=%0d got=%h exp=0", W_OF[d], act[d]);
         else n_pass++;
      end
      step();
      #2 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) drive(mk(1'b0, 1'b0, 1'b0, 8'h42, 8'h3C));
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL abort_post_reset W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
            n_chk++;
            if (act[d][20:8] !== 13'h0) $display("FAIL abort_no_late_tick W=%0d step=%0d got=%h exp=0", W_OF[d], i, act[d][20:8]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t      q[$];
      logic [11:0] pulses [ND][2];
      int          npulse [ND];
      repeat (5) q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h41, 8'h11));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h41, 8'h11));
      repeat (5) q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h43, 8'h22));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h43, 8'h22));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h43, 8'h22));
      for (int d = 0; d < ND; d++) npulse[d] = 0;
      foreach (q[i]) begin
         drive(q[i]);
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL b2b_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
            if (act[d][11:8] !== 4'h0) begin
               if (npulse[d] < 2) pulses[d][npulse[d]] = act[d][11:0];
               npulse[d]++;
            end
         end
      end
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (npulse[d] != 2) $display("FAIL b2b_count W=%0d got=%0d exp=2", W_OF[d], npulse[d]);
         else n_pass++;
         if (npulse[d] >= 2) begin
            n_chk++;
            if (pulses[d][0] !== 12'h211) $display("FAIL b2b_first W=%0d got=%h exp=%h", W_OF[d], pulses[d][0], 12'h211);
            else n_pass++;
            n_chk++;
            if (pulses[d][1] !== 12'h822) $display("FAIL b2b_second W=%0d got=%h exp=%h", W_OF[d], pulses[d][1], 12'h822);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(mk($urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  8'h3E + 8'($urandom_range(0, 7)),
                  8'($urandom)));
         step();
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (act[d] !== m_exp[d]) $display("FAIL random_model W=%0d cyc=%0d got=%h exp=%h", W_OF[d], cyc, act[d], m_exp[d]);
            else n_pass++;
         end
      end
      drive(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
      step();
      step();
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      cyc    = 0;
      test_reset();
      test_write_wait();
      test_read();
      test_unmatched();
      test_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
